micro_tile_host: RTL and testbench
==================================

# micro_tile_host

Host-side driver for the micro-tile container, i.e. the block that sits on the other end of its pins. It accepts byte-level commands over a valid/ready port and produces the container's select lines, tile reset, software-generated tile clock and input byte. It samples the tile's output byte and returns it on a valid/ready response port. It lets an on-chip controller (or a test harness) single-step any of the four tiles without external equipment.

## Interface

- SETTLE, default 2: cycles tile_sel/tile_ui are held stable before the first tile_clk edge; legal range 1..15.
- HALF, default 1: cycles per tile_clk half-period; legal range 1..15.
- clk  in  1  system clock; all logic on rising edge.
- rst  in  1  reset, synchronous, active-high.
- cmd_valid  in  1  command offered.
- cmd_ready  out  1  high only in IDLE and not in reset.
- cmd_op  in  2  00 STEP, 01 RESET, 10 READ, 11 reserved (executes as READ).
- cmd_sel  in  2  target tile index.
- cmd_data  in  8  byte driven on tile_ui.
- cmd_cnt  in  4  STEP/RESET pulse count minus one (0 → 1 pulse, 15 → 16).
- rsp_valid  out  1  response available; held until taken.
- rsp_ready  in  1  response consumer ready.
- rsp_data  out  8  sampled tile_uo.
- busy  out  1  state ≠ IDLE.
- tile_sel  out  2  container select (drives uio[1:0]).
- tile_ui  out  8  container input byte.
- tile_clk  out  1  generated tile clock; registered, glitch-free.
- tile_rst_n  out  1  tile reset, active-low.
- tile_uo  in  8  container output byte; synchronous to clk (sampled directly).

## Operation

- States: IDLE, SETUP, HIGH, LOW, RESP.
- IDLE: on cmd_valid && cmd_ready, register the command fields. On the next cycle, drive tile_sel = cmd_sel and tile_ui = cmd_data. Load timer = SETTLE and go to SETUP.
- SETUP: tile_clk = 0. When the timer expires: STEP/RESET go to HIGH with pulse counter = cmd_cnt; READ goes to RESP, sampling tile_uo on the final SETUP cycle.
- HIGH: tile_clk = 1 for HALF cycles, then LOW.
- LOW: tile_clk = 0 for HALF cycles. At the end, if pulse counter = 0, sample tile_uo into rsp_data and go to RESP. Otherwise decrement the counter and go to HIGH.
- RESET op: tile_rst_n = 0 from SETUP entry through the last LOW cycle. tile_rst_n returns to 1 on RESP entry. Its response is tile_uo as sampled while still in reset.
- STEP/READ ops: tile_rst_n = 1.
- RESP: rsp_valid = 1. Stay until rsp_ready, then go to IDLE. tile_sel and tile_ui keep their last value in IDLE; tile_clk stays 0.
- Reserved op 11 behaves exactly as READ.
- cmd_sel, cmd_data, cmd_op and cmd_cnt are ignored except at acceptance.

## Timing

- Reset values: tile_sel = 0, tile_ui = 0, tile_clk = 0, tile_rst_n = 0, rsp_valid = 0, rsp_data = 0, busy = 0, cmd_ready = 0 while rst is high.
- After reset: IDLE, cmd_ready = 1, tile_rst_n = 0. Tiles stay held in reset until the first STEP/READ is accepted.
- Latency, accept cycle t to first rsp_valid:
  - STEP/RESET: t + SETTLE + 2·HALF·(cmd_cnt+1) + 1.
  - READ: t + SETTLE + 1.
- Defaults, STEP cnt=0: SETUP t+1..t+2, tile_clk high t+3, low t+4, rsp_valid t+5.
- tile_clk rising edges = cmd_cnt+1 per STEP/RESET, exactly. No edge occurs while tile_sel or tile_ui is changing.
- The response is accepted on the same cycle rsp_ready rises. The next command can be accepted on the following cycle; there is no back-to-back overlap.
- rsp_valid held with rsp_ready low: rsp_data stable, no new command accepted.
- rst during any state: all outputs take their reset values on the next edge. The in-flight command is dropped with no response. tile_clk never produces a runt high pulse shorter than HALF except when truncated by rst.
- cmd_cnt = 15: 16 pulses, counter must not wrap.

## Structure

- Package micro_tile_host_pkg: op encoding constants (OP_STEP, OP_RESET, OP_READ), state enum, timer width constant (4 bits).
- One sub-module, micro_tile_host_timer: loadable 4-bit down-counter with expire flag, used for SETTLE and HALF. The pulse counter lives in the top.

## Test plan

- Post-reset READ sel=2, data=0xA5: tile_sel=2 and tile_ui=0xA5 from t+1, no tile_clk edges, rsp_valid at t+3 with rsp_data = tile_uo.
- RESET sel=1, cnt=3: exactly 4 tile_clk pulses with tile_rst_n=0 throughout, tile_rst_n=1 at RESP, rsp_valid at t+11.
- STEP sel=0, cnt=0 against a counter-tile model: rsp_data increments by 1 per command over 10 commands.
- Back-pressure: hold rsp_ready low 7 cycles: rsp_valid and rsp_data stable, cmd_ready=0, tile_clk=0.
- rst asserted mid-HIGH of a STEP cnt=15: next cycle tile_clk=0, tile_rst_n=0, rsp_valid=0, cmd_ready=1 after release.
- Op 11 with HALF=3, SETTLE=5: identical waveform to READ, rsp_valid at t+6.

Source files
------------

// File: rtl/micro_tile_host_pkg.sv
// micro_tile_host_pkg
// Shared definitions for the micro-tile host driver.
//   - command opcode encoding (op_e)
//   - FSM state encoding (state_t plus ST_* constants)
//   - width of the SETTLE/HALF phase timer
//   - is_pulse_op(): true for opcodes that generate tile_clk pulses
package micro_tile_host_pkg;

   localparam int TMR_W = 4;

   typedef enum logic [1:0] {
      OP_STEP  = 2'b00,
      OP_RESET = 2'b01,
      OP_READ  = 2'b10,
      OP_RSVD  = 2'b11
   } op_e;

   typedef logic [2:0] state_t;

   localparam state_t ST_IDLE  = 3'd0;
   localparam state_t ST_SETUP = 3'd1;
   localparam state_t ST_HIGH  = 3'd2;
   localparam state_t ST_LOW   = 3'd3;
   localparam state_t ST_RESP  = 3'd4;

   // The reserved opcode runs as READ, so only STEP and RESET clock the tile.
   function automatic logic is_pulse_op(op_e op);
      return (op == OP_STEP) || (op == OP_RESET);
   endfunction

endpackage

// File: rtl/micro_tile_host_if.sv
// micro_tile_host_if
// Command/response port of the micro-tile host driver.
//   cmd_valid/cmd_ready  command handshake
//   cmd_op/cmd_sel/cmd_data/cmd_cnt  command fields
//   rsp_valid/rsp_ready  response handshake
//   rsp_data             sampled tile output byte
// master: the controller issuing commands. slave: micro_tile_host.
interface micro_tile_host_if;

   logic       cmd_valid;
   logic       cmd_ready;
   logic [1:0] cmd_op;
   logic [1:0] cmd_sel;
   logic [7:0] cmd_data;
   logic [3:0] cmd_cnt;
   logic       rsp_valid;
   logic       rsp_ready;
   logic [7:0] rsp_data;

   modport master (
      output cmd_valid, cmd_op, cmd_sel, cmd_data, cmd_cnt, rsp_ready,
      input  cmd_ready, rsp_valid, rsp_data
   );

   modport slave (
      input  cmd_valid, cmd_op, cmd_sel, cmd_data, cmd_cnt, rsp_ready,
      output cmd_ready, rsp_valid, rsp_data
   );

endinterface

// File: rtl/micro_tile_host_timer.sv
// micro_tile_host_timer
// Loadable down-counter that times the SETUP, HIGH and LOW phases.
//   clk, rst      system clock, synchronous active-high reset
//   load_i        load load_val_i (has priority over dec_i)
//   load_val_i    phase length minus one
//   dec_i         count down by one, stopping at zero
//   expired_o     terminal count reached (count is zero)
// A phase of N cycles is timed by loading N-1 on entry and leaving on
// the cycle expired_o is high.
module micro_tile_host_timer
   import micro_tile_host_pkg::*;
(
   input  logic             clk,
   input  logic             rst,
   input  logic             load_i,
   input  logic [TMR_W-1:0] load_val_i,
   input  logic             dec_i,
   output logic             expired_o
);

   logic [TMR_W-1:0] count_q;
   logic [TMR_W-1:0] count_d;

   always_comb begin
      count_d = count_q;
      if (load_i) begin
         count_d = load_val_i;
      end else if (dec_i && (count_q != '0)) begin
         count_d = count_q - 1'b1;
      end
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         count_q <= '0;
      end else begin
         count_q <= count_d;
      end
   end

   assign expired_o = (count_q == '0);

endmodule

// File: rtl/micro_tile_host.sv
// micro_tile_host
// Host-side driver for the micro-tile container: accepts STEP/RESET/READ
// commands, drives the container select, input byte, reset and a
// software-generated tile clock, and returns the sampled tile output byte.
//   clk, rst       system clock, synchronous active-high reset
//   bus            command/response port (slave side)
//   busy_o         FSM not idle
//   tile_sel_o     container select
//   tile_ui_o      container input byte
//   tile_clk_o     generated tile clock (registered)
//   tile_rst_n_o   tile reset, active-low
//   tile_uo_i      container output byte, synchronous to clk
// Parameters: SETTLE (1..15) select/data settle cycles before the first
// tile_clk edge, HALF (1..15) cycles per tile_clk half-period.
//
// state | meaning
// IDLE  | waiting for a command; cmd_ready high
// SETUP | tile_sel/tile_ui settling, tile_clk low, SETTLE cycles
// HIGH  | tile_clk high for HALF cycles
// LOW   | tile_clk low for HALF cycles; last pulse samples tile_uo
// RESP  | rsp_valid high until rsp_ready
module micro_tile_host
   import micro_tile_host_pkg::*;
#(
   parameter int unsigned SETTLE = 2,
   parameter int unsigned HALF   = 1
)(
   input  logic                      clk,
   input  logic                      rst,
   micro_tile_host_if.slave          bus,
   output logic                      busy_o,
   output logic [1:0]                tile_sel_o,
   output logic [7:0]                tile_ui_o,
   output logic                      tile_clk_o,
   output logic                      tile_rst_n_o,
   input  logic [7:0]                tile_uo_i
);

   localparam logic [TMR_W-1:0] SETTLE_LD = TMR_W'(SETTLE - 1);
   localparam logic [TMR_W-1:0] HALF_LD   = TMR_W'(HALF - 1);

   state_t           state_q, state_d;
   op_e              op_q, op_d;
   logic [3:0]       pulse_q, pulse_d;
   logic [1:0]       sel_q, sel_d;
   logic [7:0]       ui_q, ui_d;
   logic             rst_n_q, rst_n_d;
   logic             clk_q, clk_d;
   logic [7:0]       rsp_data_q, rsp_data_d;

   logic             tmr_load;
   logic [TMR_W-1:0] tmr_load_val;
   logic             tmr_dec;
   logic             tmr_expired;

   micro_tile_host_timer u_timer (
      .clk        (clk),
      .rst        (rst),
      .load_i     (tmr_load),
      .load_val_i (tmr_load_val),
      .dec_i      (tmr_dec),
      .expired_o  (tmr_expired)
   );

   always_comb begin
      state_d      = state_q;
      op_d         = op_q;
      pulse_d      = pulse_q;
      sel_d        = sel_q;
      ui_d         = ui_q;
      rst_n_d      = rst_n_q;
      rsp_data_d   = rsp_data_q;
      tmr_load     = 1'b0;
      tmr_load_val = SETTLE_LD;
      tmr_dec      = 1'b0;

      case (state_q)
         ST_IDLE: begin
            if (bus.cmd_valid) begin
               op_d         = op_e'(bus.cmd_op);
               pulse_d      = bus.cmd_cnt;
               sel_d        = bus.cmd_sel;
               ui_d         = bus.cmd_data;
               // RESET holds the tile in reset from SETUP entry onward;
               // any other op releases it.
               rst_n_d      = (op_e'(bus.cmd_op) != OP_RESET);
               tmr_load     = 1'b1;
               tmr_load_val = SETTLE_LD;
               state_d      = ST_SETUP;
            end
         end

         ST_SETUP: begin
            if (tmr_expired) begin
               if (is_pulse_op(op_q)) begin
                  tmr_load     = 1'b1;
                  tmr_load_val = HALF_LD;
                  state_d      = ST_HIGH;
               end else begin
                  rsp_data_d = tile_uo_i;
                  state_d    = ST_RESP;
               end
            end else begin
               tmr_dec = 1'b1;
            end
         end

         ST_HIGH: begin
            if (tmr_expired) begin
               tmr_load     = 1'b1;
               tmr_load_val = HALF_LD;
               state_d      = ST_LOW;
            end else begin
               tmr_dec = 1'b1;
            end
         end

         ST_LOW: begin
            if (tmr_expired) begin
               if (pulse_q == 4'd0) begin
                  // Sampled on the last reset cycle for a RESET op, so the
                  // response reflects the tile while still held in reset.
                  rsp_data_d = tile_uo_i;
                  rst_n_d    = 1'b1;
                  state_d    = ST_RESP;
               end else begin
                  pulse_d      = pulse_q - 4'd1;
                  tmr_load     = 1'b1;
                  tmr_load_val = HALF_LD;
                  state_d      = ST_HIGH;
               end
            end else begin
               tmr_dec = 1'b1;
            end
         end

         ST_RESP: begin
            if (bus.rsp_ready) begin
               state_d = ST_IDLE;
            end
         end

         default: begin
            state_d = ST_IDLE;
         end
      endcase

      // tile_clk is a pure function of the next state, registered, so it
      // is glitch-free and high for exactly the HIGH cycles.
      clk_d = (state_d == ST_HIGH);
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         state_q    <= ST_IDLE;
         op_q       <= OP_STEP;
         pulse_q    <= '0;
         sel_q      <= '0;
         ui_q       <= '0;
         rst_n_q    <= 1'b0;
         clk_q      <= 1'b0;
         rsp_data_q <= '0;
      end else begin
         state_q    <= state_d;
         op_q       <= op_d;
         pulse_q    <= pulse_d;
         sel_q      <= sel_d;
         ui_q       <= ui_d;
         rst_n_q    <= rst_n_d;
         clk_q      <= clk_d;
         rsp_data_q <= rsp_data_d;
      end
   end

   assign bus.cmd_ready = (state_q == ST_IDLE) && !rst;
   assign bus.rsp_valid = (state_q == ST_RESP);
   assign bus.rsp_data  = rsp_data_q;
   assign busy_o        = (state_q != ST_IDLE);
   assign tile_sel_o    = sel_q;
   assign tile_ui_o     = ui_q;
   assign tile_clk_o    = clk_q;
   assign tile_rst_n_o  = rst_n_q;

endmodule

// File: tb/tb_micro_tile_host.sv
module tb_micro_tile_host;

   logic clk = 1'b0;
   logic rst = 1'b1;
   always #5 clk = ~clk;

   micro_tile_host_if bus1 ();
   micro_tile_host_if bus2 ();

   logic       busy1, tclk1, trstn1, busy2, tclk2, trstn2;
   logic [1:0] tsel1, tsel2;
   logic [7:0] tui1, tuo1, tui2, tuo2;

   micro_tile_host dut (
      .clk          (clk),
      .rst          (rst),
      .bus          (bus1.slave),
      .busy_o       (busy1),
      .tile_sel_o   (tsel1),
      .tile_ui_o    (tui1),
      .tile_clk_o   (tclk1),
      .tile_rst_n_o (trstn1),
      .tile_uo_i    (tuo1)
   );

   micro_tile_host #(.SETTLE(5), .HALF(3)) dut2 (
      .clk          (clk),
      .rst          (rst),
      .bus          (bus2.slave),
      .busy_o       (busy2),
      .tile_sel_o   (tsel2),
      .tile_ui_o    (tui2),
      .tile_clk_o   (tclk2),
      .tile_rst_n_o (trstn2),
      .tile_uo_i    (tuo2)
   );

   // Counter-tile environment for dut: one counter per tile, cleared while
   // tile_rst_n is low, incremented on each rising tile_clk of the selected tile.
   logic [7:0] ctr [4];
   logic       tclk1_prev = 1'b0, tclk2_prev = 1'b0;
   int         cyc = 0, edges1 = 0, edges2 = 0, viol1 = 0, hi1 = 0;

   always @(posedge clk) begin
      cyc        <= cyc + 1;
      tclk1_prev <= tclk1;
      tclk2_prev <= tclk2;
      if (tclk1 === 1'b1 && tclk1_prev === 1'b0) edges1 <= edges1 + 1;
      if (tclk2 === 1'b1 && tclk2_prev === 1'b0) edges2 <= edges2 + 1;
      if (tclk1 === 1'b1 && trstn1 === 1'b1) viol1 <= viol1 + 1;
      if (tclk1 === 1'b1) hi1 <= hi1 + 1;
      if (trstn1 !== 1'b1) begin
         for (int i = 0; i < 4; i++) ctr[i] <= 8'd0;
      end else if (tclk1 === 1'b1 && tclk1_prev === 1'b0) begin
         ctr[tsel1] <= ctr[tsel1] + 8'd1;
      end
   end

   assign tuo1 = {tsel1, 6'b0} + ctr[tsel1];
   assign tuo2 = tui2 ^ {6'b0, tsel2};

   int         n_cmp = 0;
   int         n_err = 0;
   logic [7:0] sb1 [$];
   logic [7:0] sb2 [$];
   logic [7:0] exp_ctr [4];

   task automatic send1(input logic [1:0] op, input logic [1:0] sel, input logic [7:0] data,
                        input logic [3:0] cnt, output int t, output bit ok);
      ok = 1'b0;
      t  = 0;
      bus1.cmd_valid = 1'b1;
      bus1.cmd_op    = op;
      bus1.cmd_sel   = sel;
      bus1.cmd_data  = data;
      bus1.cmd_cnt   = cnt;
      for (int i = 0; i < 50; i++) begin
         if (bus1.cmd_ready === 1'b1) begin
            t  = cyc;
            ok = 1'b1;
            break;
         end
         @(negedge clk);
      end
      @(negedge clk);
      bus1.cmd_valid = 1'b0;
      bus1.cmd_op    = ~op;
      bus1.cmd_sel   = ~sel;
      bus1.cmd_data  = ~data;
      bus1.cmd_cnt   = ~cnt;
   endtask

   task automatic send2(input logic [1:0] op, input logic [1:0] sel, input logic [7:0] data,
                        output int t, output bit ok);
      ok = 1'b0;
      t  = 0;
      bus2.cmd_valid = 1'b1;
      bus2.cmd_op    = op;
      bus2.cmd_sel   = sel;
      bus2.cmd_data  = data;
      bus2.cmd_cnt   = 4'd7;
      for (int i = 0; i < 50; i++) begin
         if (bus2.cmd_ready === 1'b1) begin
            t  = cyc;
            ok = 1'b1;
            break;
         end
         @(negedge clk);
      end
      @(negedge clk);
      bus2.cmd_valid = 1'b0;
      bus2.cmd_data  = ~data;
   endtask

   task automatic wait_rsp1(output int t, output bit ok);
      ok = 1'b0;
      t  = 0;
      for (int i = 0; i < 200; i++) begin
         if (bus1.rsp_valid === 1'b1) begin
            t  = cyc;
            ok = 1'b1;
            break;
         end
         @(negedge clk);
      end
   endtask

   task automatic wait_rsp2(output int t, output bit ok);
      ok = 1'b0;
      t  = 0;
      for (int i = 0; i < 200; i++) begin
         if (bus2.rsp_valid === 1'b1) begin
            t  = cyc;
            ok = 1'b1;
            break;
         end
         @(negedge clk);
      end
   endtask

   task automatic take_rsp1();
      bus1.rsp_ready = 1'b1;
      @(negedge clk);
      bus1.rsp_ready = 1'b0;
   endtask

   task automatic take_rsp2();
      bus2.rsp_ready = 1'b1;
      @(negedge clk);
      bus2.rsp_ready = 1'b0;
   endtask

   task automatic test_reset();
      repeat (3) @(negedge clk);
      n_cmp++;
      if (bus1.cmd_ready !== 1'b0 || busy1 !== 1'b0 || bus1.rsp_valid !== 1'b0)
         $display("FAIL reset_handshake: ready=%b busy=%b rsp_valid=%b required 0/0/0",
                  bus1.cmd_ready, busy1, bus1.rsp_valid);
         else ;
      if (bus1.cmd_ready !== 1'b0 || busy1 !== 1'b0 || bus1.rsp_valid !== 1'b0) n_err++;
      n_cmp++;
      if (tclk1 !== 1'b0 || trstn1 !== 1'b0 || tsel1 !== 2'd0 || tui1 !== 8'd0 || bus1.rsp_data !== 8'd0) begin
         $display("FAIL reset_tile: clk=%b rst_n=%b sel=%0d ui=%h rsp_data=%h required 0/0/0/00/00",
                  tclk1, trstn1, tsel1, tui1, bus1.rsp_data);
         n_err++;
      end
      rst = 1'b0;
      @(negedge clk);
      n_cmp++;
      if (bus1.cmd_ready !== 1'b1 || trstn1 !== 1'b0) begin
         $display("FAIL post_reset: ready=%b rst_n=%b required 1/0", bus1.cmd_ready, trstn1);
         n_err++;
      end
   endtask

   task automatic test_read();
      int t, tr, e0;
      bit ok;
      logic [7:0] got, exp;
      sb1.push_back({2'd2, 6'b0} + exp_ctr[2]);
      e0 = edges1;
      send1(2'b10, 2'd2, 8'hA5, 4'd9, t, ok);
      n_cmp++;
      if (!ok || tsel1 !== 2'd2 || tui1 !== 8'hA5) begin
         $display("FAIL read_drive: accepted=%0d sel=%0d ui=%h required 1/2/a5", ok, tsel1, tui1);
         n_err++;
      end
      wait_rsp1(tr, ok);
      n_cmp++;
      if (!ok || tr != t + 3) begin
         $display("FAIL read_latency: got rsp at +%0d (seen=%0d) required +3", tr - t, ok);
         n_err++;
      end
      n_cmp++;
      got = bus1.rsp_data;
      exp = (sb1.size() != 0) ? sb1.pop_front() : 8'hxx;
      if (got !== exp) begin
         $display("FAIL read_data: got %h required %h", got, exp);
         n_err++;
      end
      n_cmp++;
      if (edges1 != e0 || trstn1 !== 1'b1) begin
         $display("FAIL read_no_clk: edges=%0d rst_n=%b required 0/1", edges1 - e0, trstn1);
         n_err++;
      end
      take_rsp1();
      n_cmp++;
      if (bus1.rsp_valid !== 1'b0 || bus1.cmd_ready !== 1'b1) begin
         $display("FAIL read_release: rsp_valid=%b ready=%b required 0/1", bus1.rsp_valid, bus1.cmd_ready);
         n_err++;
      end
   endtask

   task automatic test_reset_op();
      int t, tr, e0, v0, h0;
      bit ok;
      logic [7:0] got, exp;
      for (int i = 0; i < 4; i++) exp_ctr[i] = 8'd0;
      sb1.push_back({2'd1, 6'b0});
      e0 = edges1; v0 = viol1; h0 = hi1;
      send1(2'b01, 2'd1, 8'h5A, 4'd3, t, ok);
      n_cmp++;
      if (!ok || trstn1 !== 1'b0 || tsel1 !== 2'd1) begin
         $display("FAIL rstop_setup: accepted=%0d rst_n=%b sel=%0d required 1/0/1", ok, trstn1, tsel1);
         n_err++;
      end
      wait_rsp1(tr, ok);
      n_cmp++;
      if (!ok || tr != t + 11) begin
         $display("FAIL rstop_latency: got +%0d (seen=%0d) required +11", tr - t, ok);
         n_err++;
      end
      n_cmp++;
      if (edges1 - e0 != 4 || hi1 - h0 != 4 || viol1 != v0) begin
         $display("FAIL rstop_pulses: edges=%0d high_cycles=%0d rst_released_high=%0d required 4/4/0",
                  edges1 - e0, hi1 - h0, viol1 - v0);
         n_err++;
      end
      n_cmp++;
      if (trstn1 !== 1'b1) begin
         $display("FAIL rstop_release: rst_n=%b required 1", trstn1);
         n_err++;
      end
      n_cmp++;
      got = bus1.rsp_data;
      exp = (sb1.size() != 0) ? sb1.pop_front() : 8'hxx;
      if (got !== exp) begin
         $display("FAIL rstop_data: got %h required %h", got, exp);
         n_err++;
      end
      take_rsp1();
   endtask

   task automatic test_step_counter();
      int t, tr, e0;
      bit ok;
      logic [7:0] got, exp;
      e0 = edges1;
      for (int k = 0; k < 10; k++) begin
         exp_ctr[0] = exp_ctr[0] + 8'd1;
         sb1.push_back({2'd0, 6'b0} + exp_ctr[0]);
         send1(2'b00, 2'd0, 8'(k * 17), 4'd0, t, ok);
         wait_rsp1(tr, ok);
         n_cmp++;
         if (!ok || tr != t + 5) begin
            $display("FAIL step_latency[%0d]: got +%0d (seen=%0d) required +5", k, tr - t, ok);
            n_err++;
         end
         n_cmp++;
         got = bus1.rsp_data;
         exp = (sb1.size() != 0) ? sb1.pop_front() : 8'hxx;
         if (got !== exp) begin
            $display("FAIL step_data[%0d]: got %h required %h", k, got, exp);
            n_err++;
         end
         take_rsp1();
      end
      n_cmp++;
      if (edges1 - e0 != 10) begin
         $display("FAIL step_edges: got %0d required 10", edges1 - e0);
         n_err++;
      end
   endtask

   task automatic test_max_count();
      int t, tr, e0;
      bit ok;
      logic [7:0] got, exp;
      exp_ctr[1] = exp_ctr[1] + 8'd16;
      sb1.push_back({2'd1, 6'b0} + exp_ctr[1]);
      e0 = edges1;
      send1(2'b00, 2'd1, 8'h3C, 4'd15, t, ok);
      wait_rsp1(tr, ok);
      n_cmp++;
      if (!ok || tr != t + 35) begin
         $display("FAIL max_latency: got +%0d (seen=%0d) required +35", tr - t, ok);
         n_err++;
      end
      n_cmp++;
      if (edges1 - e0 != 16) begin
         $display("FAIL max_edges: got %0d required 16", edges1 - e0);
         n_err++;
      end
      n_cmp++;
      got = bus1.rsp_data;
      exp = (sb1.size() != 0) ? sb1.pop_front() : 8'hxx;
      if (got !== exp) begin
         $display("FAIL max_data: got %h required %h", got, exp);
         n_err++;
      end
      take_rsp1();
   endtask

   task automatic test_backpressure();
      int t, tr;
      bit ok, stable;
      logic [7:0] d0, exp;
      exp_ctr[3] = exp_ctr[3] + 8'd2;
      sb1.push_back({2'd3, 6'b0} + exp_ctr[3]);
      send1(2'b00, 2'd3, 8'h77, 4'd1, t, ok);
      wait_rsp1(tr, ok);
      n_cmp++;
      if (!ok || tr != t + 7) begin
         $display("FAIL bp_latency: got +%0d (seen=%0d) required +7", tr - t, ok);
         n_err++;
      end
      d0 = bus1.rsp_data;
      stable = 1'b1;
      bus1.cmd_valid = 1'b1;
      bus1.cmd_op    = 2'b10;
      bus1.cmd_sel   = 2'd0;
      for (int i = 0; i < 7; i++) begin
         @(negedge clk);
         if (bus1.rsp_valid !== 1'b1 || bus1.rsp_data !== d0 || bus1.cmd_ready !== 1'b0 || tclk1 !== 1'b0)
            stable = 1'b0;
      end
      bus1.cmd_valid = 1'b0;
      n_cmp++;
      if (!stable) begin
         $display("FAIL bp_hold: stable=%0d required 1", stable);
         n_err++;
      end
      n_cmp++;
      exp = (sb1.size() != 0) ? sb1.pop_front() : 8'hxx;
      if (d0 !== exp) begin
         $display("FAIL bp_data: got %h required %h", d0, exp);
         n_err++;
      end
      take_rsp1();
      n_cmp++;
      if (bus1.rsp_valid !== 1'b0 || bus1.cmd_ready !== 1'b1 || busy1 !== 1'b0) begin
         $display("FAIL bp_release: rsp_valid=%b ready=%b busy=%b required 0/1/0",
                  bus1.rsp_valid, bus1.cmd_ready, busy1);
         n_err++;
      end
   endtask

   task automatic test_rst_mid();
      int t, e0;
      bit ok, found, quiet;
      e0 = edges1;
      found = 1'b0;
      send1(2'b00, 2'd0, 8'hE1, 4'd15, t, ok);
      for (int i = 0; i < 100; i++) begin
         if (tclk1 === 1'b1 && edges1 - e0 >= 2) begin
            found = 1'b1;
            break;
         end
         @(negedge clk);
      end
      n_cmp++;
      if (!ok || !found) begin
         $display("FAIL rst_mid_reach_high: accepted=%0d found=%0d required 1/1", ok, found);
         n_err++;
      end
      rst = 1'b1;
      @(negedge clk);
      n_cmp++;
      if (tclk1 !== 1'b0 || trstn1 !== 1'b0 || bus1.rsp_valid !== 1'b0 || busy1 !== 1'b0 || bus1.cmd_ready !== 1'b0) begin
         $display("FAIL rst_mid_outputs: clk=%b rst_n=%b rsp_valid=%b busy=%b ready=%b required 0/0/0/0/0",
                  tclk1, trstn1, bus1.rsp_valid, busy1, bus1.cmd_ready);
         n_err++;
      end
      rst = 1'b0;
      for (int i = 0; i < 4; i++) exp_ctr[i] = 8'd0;
      @(negedge clk);
      n_cmp++;
      if (bus1.cmd_ready !== 1'b1 || trstn1 !== 1'b0) begin
         $display("FAIL rst_mid_release: ready=%b rst_n=%b required 1/0", bus1.cmd_ready, trstn1);
         n_err++;
      end
      quiet = 1'b1;
      for (int i = 0; i < 40; i++) begin
         if (bus1.rsp_valid !== 1'b0 || tclk1 !== 1'b0) quiet = 1'b0;
         @(negedge clk);
      end
      n_cmp++;
      if (!quiet) begin
         $display("FAIL rst_mid_dropped: quiet=%0d required 1", quiet);
         n_err++;
      end
   endtask

   task automatic test_op11();
      int t, tr, e0;
      bit ok;
      logic [1:0] ops [2];
      logic [7:0] got, exp;
      ops[0] = 2'b10;
      ops[1] = 2'b11;
      for (int k = 0; k < 2; k++) begin
         sb2.push_back(8'h11 ^ 8'h01);
         e0 = edges2;
         send2(ops[k], 2'd1, 8'h11, t, ok);
         n_cmp++;
         if (!ok || tsel2 !== 2'd1 || tui2 !== 8'h11 || trstn2 !== 1'b1) begin
            $display("FAIL op%0d_drive: accepted=%0d sel=%0d ui=%h rst_n=%b required 1/1/11/1",
                     ops[k], ok, tsel2, tui2, trstn2);
            n_err++;
         end
         wait_rsp2(tr, ok);
         n_cmp++;
         if (!ok || tr != t + 6 || edges2 != e0) begin
            $display("FAIL op%0d_timing: got +%0d edges=%0d (seen=%0d) required +6/0", ops[k], tr - t, edges2 - e0, ok);
            n_err++;
         end
         n_cmp++;
         got = bus2.rsp_data;
         exp = (sb2.size() != 0) ? sb2.pop_front() : 8'hxx;
         if (got !== exp) begin
            $display("FAIL op%0d_data: got %h required %h", ops[k], got, exp);
            n_err++;
         end
         take_rsp2();
      end
   endtask

   initial begin
      bus1.cmd_valid = 1'b0; bus1.cmd_op = 2'b00; bus1.cmd_sel = 2'd0;
      bus1.cmd_data  = 8'd0; bus1.cmd_cnt = 4'd0; bus1.rsp_ready = 1'b0;
      bus2.cmd_valid = 1'b0; bus2.cmd_op = 2'b00; bus2.cmd_sel = 2'd0;
      bus2.cmd_data  = 8'd0; bus2.cmd_cnt = 4'd0; bus2.rsp_ready = 1'b0;
      for (int i = 0; i < 4; i++) exp_ctr[i] = 8'd0;
      test_reset();
      test_read();
      test_reset_op();
      test_step_counter();
      test_max_count();
      test_backpressure();
      test_rst_mid();
      test_op11();
      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
      $finish;
   end

   initial begin
      #300000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

endmodule
